// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller command port between NUM_PORTS requesters.
// Port 0 (VGA) has fixed priority bounded by MAX_VGA_RUN; ports 1..N-1 are served round-robin.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests on every edge
// ISSUE | latched command presented to the controller, waiting for sdram_ready
// BUSY  | command accepted; forward read beats and completion to the owner
module sdram_arbiter #(
  parameter int NUM_PORTS   = 3,
  parameter int MAX_VGA_RUN = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_PORTS-1:0]    port_request,
  output logic [NUM_PORTS-1:0]    port_ready,
  input  logic [26*NUM_PORTS-1:0] port_address,
  input  logic [NUM_PORTS-1:0]    port_write,
  input  logic [32*NUM_PORTS-1:0] port_wdata,
  input  logic [4*NUM_PORTS-1:0]  port_wmask,
  output logic [NUM_PORTS-1:0]    port_rvalid,
  output logic [31:0]             port_rdata,
  output logic [25:0]             port_raddress,
  output logic [NUM_PORTS-1:0]    port_complete,
  output logic                    sdram_request,
  input  logic                    sdram_ready,
  output logic [25:0]             sdram_address,
  output logic                    sdram_write,
  output logic [31:0]             sdram_wdata,
  output logic [3:0]              sdram_wmask,
  input  logic                    sdram_rvalid,
  input  logic [31:0]             sdram_rdata,
  input  logic [25:0]             sdram_raddress,
  input  logic                    sdram_complete
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int RUN_W = $clog2(MAX_VGA_RUN + 1);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_VGA_RUN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [RUN_W-1:0]     r_vga_run;
  logic [25:0]          r_address;
  logic                 r_write;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wmask;
  logic                 r_sdram_request;
  logic [NUM_PORTS-1:0] r_port_ready;
  logic [NUM_PORTS-1:0] r_port_rvalid;
  logic [NUM_PORTS-1:0] r_port_complete;
  logic [31:0]          r_rdata;
  logic [25:0]          r_raddress;

  logic                 w_any_req;
  logic                 w_others_req;
  logic                 w_vga_win;
  logic                 w_rr_hit;
  logic [IDX_W-1:0]     w_rr_win;
  logic [IDX_W-1:0]     w_winner;
  logic [IDX_W-1:0]     w_rr_next;

  // Maps a search offset from the round-robin pointer onto ports 1..N-1 with wrap.
  function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] ptr, input int offset);
    int slot;
    slot = int'(ptr) - 1 + offset;
    if (slot >= NUM_PORTS - 1) slot = slot - (NUM_PORTS - 1);
    return IDX_W'(slot + 1);
  endfunction

  assign w_any_req    = |port_request;
  assign w_others_req = |port_request[NUM_PORTS-1:1];
  assign w_vga_win    = port_request[0] && !((r_vga_run >= RUN_MAX) && w_others_req);

  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_win = '0;
    for (int i = 0; i < NUM_PORTS - 1; i++) begin
      if (!w_rr_hit && port_request[rr_slot(r_rr_ptr, i)]) begin
        w_rr_hit = 1'b1;
        w_rr_win = rr_slot(r_rr_ptr, i);
      end
    end
  end

  assign w_winner  = w_vga_win ? '0 : w_rr_win;
  assign w_rr_next = (w_winner == LAST_PORT) ? IDX_W'(1) : w_winner + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_owner         <= '0;
      r_rr_ptr        <= IDX_W'(1);
      r_vga_run       <= '0;
      r_address       <= '0;
      r_write         <= 1'b0;
      r_wdata         <= '0;
      r_wmask         <= '0;
      r_sdram_request <= 1'b0;
      r_port_ready    <= '0;
      r_port_rvalid   <= '0;
      r_port_complete <= '0;
      r_rdata         <= '0;
      r_raddress      <= '0;
    end else begin
      r_port_ready    <= '0;
      r_port_rvalid   <= '0;
      r_port_complete <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner                <= w_winner;
            r_address              <= port_address[26*w_winner +: 26];
            r_write                <= port_write[w_winner];
            r_wdata                <= port_wdata[32*w_winner +: 32];
            r_wmask                <= port_wmask[4*w_winner +: 4];
            r_port_ready[w_winner] <= 1'b1;
            r_sdram_request        <= 1'b1;
            r_state                <= S_ISSUE;
            if (w_vga_win) begin
              if (r_vga_run < RUN_MAX) r_vga_run <= r_vga_run + 1'b1;
            end else begin
              r_vga_run <= '0;
              r_rr_ptr  <= w_rr_next;
            end
          end
        end
        S_ISSUE: begin
          // Stray controller rvalid/complete here are deliberately ignored.
          if (sdram_ready) begin
            r_sdram_request <= 1'b0;
            r_state         <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (sdram_rvalid) begin
            r_port_rvalid[r_owner] <= 1'b1;
            r_rdata                <= sdram_rdata;
            r_raddress             <= sdram_raddress;
          end
          if (sdram_complete) begin
            r_port_complete[r_owner] <= 1'b1;
            r_state                  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign port_ready    = r_port_ready;
  assign port_rvalid   = r_port_rvalid;
  assign port_complete = r_port_complete;
  assign port_rdata    = r_rdata;
  assign port_raddress = r_raddress;
  assign sdram_request = r_sdram_request;
  assign sdram_address = r_address;
  assign sdram_write   = r_write;
  assign sdram_wdata   = r_wdata;
  assign sdram_wmask   = r_wmask;

endmodule
